// File: rtl/Decoders.sv
// Shared ALU operation/shift codes plus the command-issuer state and error
// encodings and the header check.
package Decoders;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } OP_t;

  typedef enum logic [1:0] {
    No_Shift    = 2'b00,
    Shift_Right = 2'b01,
    Shift_Left  = 2'b10,
    Shift_Rsvd  = 2'b11
  } SH_t;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    OPA   = 3'd1,
    OPB   = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } CmdState_t;

  localparam logic [1:0] HDR_SYNC    = 2'b10;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_HDR     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Header is [7:6] sync, [5:4] op, [3:2] sh, [1:0] zero; sh=11 is reserved.
  function automatic logic hdr_valid(input logic [7:0] b);
    return (b[7:6] == HDR_SYNC) && (b[3:2] != 2'b11) && (b[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/alu_cmd_timeout.sv
// Wait-cycle counter for the ALU handshake: clear, load and count-enable,
// with a flag on the final allowed cycle.
module alu_cmd_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load,
  input  logic [$clog2(TIMEOUT):0] load_val,
  input  logic                     en,
  output logic                     expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Clear has priority over load, load over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + CW'(1);
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Byte-serial command front end for the ALU: header/A/B in, one start pulse
// out, bounded wait for done, result out on a valid/ready handshake.
module alu_cmd_issuer
  import Decoders::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output OP_t              alu_op,
  output SH_t              alu_sh,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  CmdState_t state;
  logic      expired;
  logic      accept;

  assign accept = in_valid && in_ready;

  // The ISSUE cycle counts as the first waited cycle, so the timeout error
  // lands exactly TIMEOUT cycles after alu_start.
  alu_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == HDR),
    .load     (state == ISSUE),
    .load_val (CW'(1)),
    .en       (state == WAIT),
    .expired  (expired)
  );

  // Command FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HDR;
      in_ready  <= 1'b0;
      alu_start <= 1'b0;
      res_valid <= 1'b0;
      err       <= ERR_NONE;
      alu_op    <= ADD;
      alu_sh    <= No_Shift;
      alu_a     <= '0;
      alu_b     <= '0;
      res_data  <= '0;
    end else begin
      alu_start <= 1'b0;
      err       <= ERR_NONE;
      case (state)
        HDR: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (hdr_valid(in_data)) begin
              alu_op <= OP_t'(in_data[5:4]);
              alu_sh <= SH_t'(in_data[3:2]);
              state  <= OPA;
            end else begin
              err <= ERR_HDR;
            end
          end
        end
        OPA: begin
          if (accept) begin
            alu_a <= WIDTH'(in_data);
            state <= OPB;
          end
        end
        OPB: begin
          if (accept) begin
            alu_b     <= WIDTH'(in_data);
            alu_start <= 1'b1;
            in_ready  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // A done on the last allowed cycle still counts as success.
          if (alu_done) begin
            res_data  <= alu_result;
            res_valid <= 1'b1;
            state     <= RESP;
          end else if (expired) begin
            err      <= ERR_TIMEOUT;
            in_ready <= 1'b1;
            state    <= HDR;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= HDR;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomised and directed bench for alu_cmd_issuer with a transaction-level
// expectation model checked every cycle.
module tb_alu_cmd_issuer;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [1:0]       alu_sh;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_start;
  logic             alu_done = 1'b0;
  logic [WIDTH-1:0] alu_result = '0;
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [1:0]       err;

  alu_cmd_issuer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_sh     (alu_sh),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Expected outputs for the current cycle
  logic             exp_in_ready, exp_start, exp_res_valid;
  logic [1:0]       exp_err, exp_op, exp_sh;
  logic [WIDTH-1:0] exp_a, exp_b, exp_res_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
  endtask

  function automatic bit hdr_ok(input logic [7:0] h);
    return (h[7:6] == 2'b10) && (h[3:2] != 2'b11) && (h[1:0] == 2'b00);
  endfunction

  // Stand-in ALU: plain arithmetic on the operands the bench sent.
  function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic set_reset_exp();
    exp_in_ready = 1'b0; exp_start = 1'b0; exp_res_valid = 1'b0; exp_err = 2'b00;
    exp_op = 2'b00; exp_sh = 2'b00; exp_a = '0; exp_b = '0; exp_res_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    exp_err   = 2'b00;
    exp_start = 1'b0;
  endtask

  // Compare process: every output against the model, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_in_ready});
      chk("alu_start", {31'd0, alu_start}, {31'd0, exp_start});
      chk("res_valid", {31'd0, res_valid}, {31'd0, exp_res_valid});
      chk("err",       {30'd0, err},       {30'd0, exp_err});
      chk("alu_op",    {30'd0, alu_op},    {30'd0, exp_op});
      chk("alu_sh",    {30'd0, alu_sh},    {30'd0, exp_sh});
      chk("alu_a",     32'(alu_a),         32'(exp_a));
      chk("alu_b",     32'(alu_b),         32'(exp_b));
      chk("res_data",  32'(res_data),      32'(exp_res_data));
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0; in_data = 8'($urandom); alu_done = 1'($urandom_range(0, 1));
      tick();
    end
    in_data = b; in_valid = 1'b1; alu_done = 1'($urandom_range(0, 1));
    tick();
    in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  // One command; done_d = cycles after alu_start that done is raised
  // (>= TIMEOUT means never), rdy_d = cycles res_ready is held low.
  task automatic run_cmd(input logic [7:0] hdr, input logic [7:0] a, input logic [7:0] b,
                         input int gap, input int done_d, input int rdy_d,
                         input bit hold_hdr, input int lit);
    logic [WIDTH-1:0] r;
    send_byte(hdr, gap);
    if (!hdr_ok(hdr)) begin
      exp_err = 2'b01;
      return;
    end
    exp_op = hdr[5:4]; exp_sh = hdr[3:2];
    send_byte(a, gap);
    exp_a = WIDTH'(a);
    send_byte(b, gap);
    exp_b = WIDTH'(b); exp_start = 1'b1; exp_in_ready = 1'b0;
    r = alu_fn(hdr[5:4], WIDTH'(a), WIDTH'(b));
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      in_valid = 1'b0;
      if (k == done_d + 1 && done_d <= TIMEOUT - 1) begin
        alu_done = 1'b0;
        exp_res_valid = 1'b1; exp_res_data = r;
        break;
      end
      if (k == TIMEOUT) begin
        alu_done = 1'b0;
        exp_err = 2'b10; exp_in_ready = 1'b1;
        if (lit >= 0) chk("timeout_err", {30'd0, err}, 32'd2);
        return;
      end
      if (k == done_d) begin alu_done = 1'b1; alu_result = r; end
      else begin alu_done = 1'b0; alu_result = WIDTH'($urandom); end
      in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
    end
    if (lit >= 0) chk("lit_res", 32'(res_data), lit[31:0]);
    for (int i = 0; i < rdy_d; i++) begin
      alu_done = 1'($urandom_range(0, 1));
      in_valid = hold_hdr ? 1'b1 : 1'($urandom_range(0, 1));
      in_data  = 8'b10_01_00_00;
      tick();
    end
    in_valid = 1'b0; alu_done = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_res_valid = 1'b0; exp_in_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] h;
    set_reset_exp();
    tick(); tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_start",     {31'd0, alu_start}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_err",       {30'd0, err},       32'd0);
    chk("rst_res_data",  32'(res_data),      32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    exp_in_ready = 1'b1;

    // SUB / Shift_Left, done two cycles after start
    run_cmd(8'b10_01_10_00, 8'h35, 8'h12, 0, 2, 1, 1'b0, 32'h23);
    chk("t1_op", {30'd0, alu_op}, 32'd1);
    chk("t1_sh", {30'd0, alu_sh}, 32'd2);
    chk("t1_a",  32'(alu_a), 32'h35);
    chk("t1_b",  32'(alu_b), 32'h12);

    // Reserved shift rejected, then a normal ADD
    run_cmd(8'b10_00_11_00, 8'h00, 8'h00, 0, 1, 0, 1'b0, -1);
    chk("bad_hdr_err", {30'd0, err}, 32'd1);
    run_cmd(8'b10_00_00_00, 8'h05, 8'h03, 0, 1, 0, 1'b0, 32'h08);

    // Never done -> timeout
    run_cmd(8'b10_10_00_00, 8'hAA, 8'h55, 1, TIMEOUT + 5, 0, 1'b0, 0);
    tick();

    // Result held for 10 cycles with headers offered
    run_cmd(8'b10_11_00_00, 8'h0C, 8'h03, 0, 4, 10, 1'b1, 32'h0F);

    // Reset in WAIT, then stray done, then OR / Shift_Right
    send_byte(8'b10_01_01_00, 1); exp_op = 2'b01; exp_sh = 2'b01;
    send_byte(8'h77, 2);          exp_a = 8'h77;
    send_byte(8'h11, 1);          exp_b = 8'h11; exp_start = 1'b1; exp_in_ready = 1'b0;
    alu_done = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    set_reset_exp();
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_a",        32'(alu_a), 32'd0);
    chk("mid_rst_op",       {30'd0, alu_op}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    exp_in_ready = 1'b1;
    alu_done = 1'b1; alu_result = 8'h5A;
    tick();
    alu_done = 1'b0;
    tick();
    run_cmd(8'b10_11_01_00, 8'hF0, 8'h0F, 1, 3, 2, 1'b0, 32'hFF);

    // Done on the final allowed cycle
    run_cmd(8'b10_00_00_00, 8'h07, 8'h09, 0, TIMEOUT - 1, 1, 1'b0, 32'h10);

    // Randomised commands
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0)
        h = {2'b10, 2'($urandom), 2'($urandom_range(0, 2)), 2'b00};
      else
        h = 8'($urandom);
      run_cmd(h, 8'($urandom), 8'($urandom), $urandom_range(0, 2),
              $urandom_range(1, TIMEOUT + 2), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), -1);
    end
    tick(); tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
